// File: rtl/serial_slave_mem_if.sv
// Serial slave bus bundle: address/write-data in, read data and handshake out.
// Optional macro SLAVE_SPLIT_EN adds the split request/grant pair.
interface serial_slave_mem_if;
  logic wdata;
  logic mode;
  logic wvalid;
  logic rdata;
  logic rvalid;
  logic ready;
`ifdef SLAVE_SPLIT_EN
  logic split;
  logic split_grant;

  modport master (
    output wdata, mode, wvalid, split_grant,
    input  rdata, rvalid, ready, split
  );
  modport slave (
    input  wdata, mode, wvalid, split_grant,
    output rdata, rvalid, ready, split
  );
`else
  modport master (
    output wdata, mode, wvalid,
    input  rdata, rvalid, ready
  );
  modport slave (
    input  wdata, mode, wvalid,
    output rdata, rvalid, ready
  );
`endif
endinterface

// File: rtl/serial_slave_mem.sv
// Memory-backed slave for the 1-bit serial system bus. Address and write data
// arrive LSB-first; read data is returned LSB-first after a programmable
// access latency so masters and the arbiter can be exercised against slow
// slaves.
// Optional macro SLAVE_SPLIT_EN: long reads release the bus with a split
// request and resume once split_grant is seen.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | ready=1, waiting for the first address bit
// ADDR       | shifting in the remaining address bits
// WDATA      | shifting in the write data word
// WRITE      | single cycle memory write (dropped when out of range)
// RLAT       | memory read on first cycle, then READ_LATENCY wait cycles
// SPLIT_WAIT | latency expired, holding split until the bus is granted back
// RDATA      | shifting out DATA_WIDTH read bits with rvalid=1
module serial_slave_mem #(
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 8,
  parameter int MEM_DEPTH       = 4096,
  parameter int READ_LATENCY    = 2,
  parameter int SPLIT_THRESHOLD = 4
) (
  input logic          clk,
  input logic          rstn,
  serial_slave_mem_if.slave bus
);

  localparam int MAX_BITS = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int LAT_W    = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam int MIDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ADDR       = 3'd1;
  localparam logic [2:0] S_WDATA      = 3'd2;
  localparam logic [2:0] S_WRITE      = 3'd3;
  localparam logic [2:0] S_RLAT       = 3'd4;
  localparam logic [2:0] S_RDATA      = 3'd5;
`ifdef SLAVE_SPLIT_EN
  localparam logic [2:0] S_SPLIT_WAIT = 3'd6;
  localparam bit         SPLIT_READ   = (READ_LATENCY >= SPLIT_THRESHOLD);
`endif

  // Catch unusable parameter sets at elaboration rather than in silicon.
  if (ADDR_WIDTH < 2 || MEM_DEPTH > (1 << ADDR_WIDTH) || SPLIT_THRESHOLD < 0) begin : g_bad_cfg
    $error("serial_slave_mem: invalid parameter set");
  end

  logic [2:0]            state;
  logic                  mode_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic [LAT_W-1:0]      lat_cnt;
  logic                  rd_load;
  logic                  addr_ok;
  logic [MIDX_W-1:0]     mem_idx;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Addresses past MEM_DEPTH alias nothing: writes drop, reads return zero.
  assign addr_ok = ({1'b0, addr_q} < DEPTH_LIM);
  assign mem_idx = addr_q[MIDX_W-1:0];

  assign bus.ready  = (state == S_IDLE);
  assign bus.rvalid = (state == S_RDATA);
  // Gated so the loaded word does not leak onto the bus while waiting.
  assign bus.rdata  = (state == S_RDATA) & shreg[0];
`ifdef SLAVE_SPLIT_EN
  assign bus.split  = SPLIT_READ && ((state == S_RLAT) || (state == S_SPLIT_WAIT));
`endif

  // Transaction sequencer: deserialise, access storage, serialise read data.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      bit_cnt <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      shreg   <= '0;
      lat_cnt <= '0;
      rd_load <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.wvalid) begin
            mode_q  <= bus.mode;
            addr_q  <= {bus.wdata, addr_q[ADDR_WIDTH-1:1]};
            bit_cnt <= CNT_W'(1);
            state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus.wvalid) begin
            // LSB-first shift: the first bit reaches addr_q[0] once all are in.
            addr_q <= {bus.wdata, addr_q[ADDR_WIDTH-1:1]};
            if (bit_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
              bit_cnt <= '0;
              if (mode_q) begin
                state <= S_WDATA;
              end else begin
                lat_cnt <= LAT_W'(READ_LATENCY);
                rd_load <= 1'b1;
                state   <= S_RLAT;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_WDATA: begin
          if (bus.wvalid) begin
            data_q <= {bus.wdata, data_q[DATA_WIDTH-1:1]};
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= S_WRITE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
        end
        S_RLAT: begin
          if (rd_load) begin
            shreg   <= addr_ok ? mem[mem_idx] : '0;
            rd_load <= 1'b0;
          end
          if (lat_cnt == '0) begin
            bit_cnt <= '0;
`ifdef SLAVE_SPLIT_EN
            state   <= SPLIT_READ ? S_SPLIT_WAIT : S_RDATA;
`else
            state   <= S_RDATA;
`endif
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
`ifdef SLAVE_SPLIT_EN
        S_SPLIT_WAIT: begin
          if (bus.split_grant) begin
            state <= S_RDATA;
          end
        end
`endif
        S_RDATA: begin
          shreg <= shreg >> 1;
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage write port; a reset landing on the WRITE cycle suppresses it.
  always_ff @(posedge clk) begin
    if (!rstn && state == S_WRITE && addr_ok) begin
      mem[mem_idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_serial_slave_mem.sv
// Scoreboard bench for serial_slave_mem: directed writes/reads push expected
// read bursts; an independent monitor checks each rvalid burst.
module tb_serial_slave_mem;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 2048;
`ifdef SLAVE_SPLIT_EN
  localparam int RL = 6;
`else
  localparam int RL = 2;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_slave_mem_if bus();

  serial_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
    .READ_LATENCY(RL), .SPLIT_THRESHOLD(4)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  typedef struct {
    int data;
    int rise;
    int nbits;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // First rvalid cycle, counted from the negedge the last address bit is driven.
  function automatic int rise_of(int k);
`ifdef SLAVE_SPLIT_EN
    return k + 12;
`else
    return k + RL + 2;
`endif
  endfunction

`ifdef SLAVE_SPLIT_EN
  // Arbiter model: grant back after split has been seen for 11 cycles.
  int scnt = 0;
  always @(negedge clk) begin
    if (bus.split) scnt++;
    else scnt = 0;
    bus.split_grant = (scnt == 11);
  end

  serial_slave_mem_if bus2();
  assign bus2.wdata       = bus.wdata;
  assign bus2.mode        = bus.mode;
  assign bus2.wvalid      = bus.wvalid;
  assign bus2.split_grant = 1'b0;

  serial_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
    .READ_LATENCY(2), .SPLIT_THRESHOLD(4)
  ) dut_short (
    .clk(clk), .rstn(rstn), .bus(bus2)
  );

  int split2_seen = 0;
  always @(negedge clk) if (bus2.split === 1'b1) split2_seen++;
`endif

  // Monitor: collect each rvalid burst and compare with the oldest expectation.
  logic in_burst = 1'b0;
  int   mb_start, mb_n, mb_bits;
  exp_t e;
  always @(negedge clk) begin
    if (bus.rvalid === 1'b1) begin
      if (!in_burst) begin
        in_burst = 1'b1;
        mb_start = cyc;
        mb_n     = 0;
        mb_bits  = 0;
`ifdef SLAVE_SPLIT_EN
        chk("split_low_in_rdata", int'(bus.split), 0);
`endif
      end
      if (mb_n < 31) mb_bits[mb_n] = bus.rdata;
      mb_n++;
    end else if (in_burst) begin
      in_burst = 1'b0;
      if (sb.size() == 0) begin
        chk("unexpected_burst", mb_n, 0);
      end else begin
        e = sb.pop_front();
        chk("rvalid_rise_cycle", mb_start, e.rise);
        chk("rvalid_length", mb_n, e.nbits);
        chk("rdata_word", mb_bits & ((1 << e.nbits) - 1), e.data & ((1 << e.nbits) - 1));
      end
    end
  end

  task automatic drive_bit(input logic b, input logic m);
    @(negedge clk);
    bus.wvalid = 1'b1;
    bus.wdata  = b;
    bus.mode   = m;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.wvalid = 1'b0;
      bus.wdata  = 1'b0;
    end
  endtask

  task automatic do_write(input int addr, input int data,
                          input int agap_at, input int agap_len,
                          input int dgap_at, input int dgap_len);
    for (int i = 0; i < AW; i++) begin
      drive_bit(addr[i], (i == 0));
      if (i == 1) chk("ready_low_in_addr", int'(bus.ready), 0);
      if (i == agap_at) gap(agap_len);
    end
    for (int j = 0; j < DW; j++) begin
      drive_bit(data[j], 1'b0);
      if (j == dgap_at) gap(dgap_len);
    end
    @(negedge clk);
    bus.wvalid = 1'b0;
    chk("ready_low_in_write", int'(bus.ready), 0);
    @(negedge clk);
    chk("ready_after_write", int'(bus.ready), 1);
  endtask

  // Mode is driven high after the first bit to confirm it is ignored there.
  task automatic do_read(input int addr, input int data, input int nbits, output int k);
    exp_t x;
    for (int i = 0; i < AW; i++) drive_bit(addr[i], (i != 0));
    k = cyc;
    x.data  = data;
    x.rise  = rise_of(k);
    x.nbits = nbits;
    sb.push_back(x);
    @(negedge clk);
    bus.wvalid = 1'b0;
    bus.wdata  = 1'b0;
    bus.mode   = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !in_burst && bus.ready === 1'b1) ok = 1'b1;
    end
    chk("transaction_completes", int'(ok), 1);
  endtask

  int k, r;

  initial begin
    bus.wvalid = 1'b0;
    bus.wdata  = 1'b0;
    bus.mode   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(bus.ready), 1);
    chk("reset_rvalid", int'(bus.rvalid), 0);
    chk("reset_rdata", int'(bus.rdata), 0);
`ifdef SLAVE_SPLIT_EN
    chk("reset_split", int'(bus.split), 0);
`endif
    rstn = 1'b0;
    gap(2);

    // Basic write then read.
    do_write(12'h123, 8'hA5, -1, 0, -1, 0);
    do_read(12'h123, 8'hA5, DW, k);
    wait_done();

    // Gaps inside address and data phases.
    do_write(12'h7FF, 8'h3C, 5, 3, 3, 2);
    do_read(12'h7FF, 8'h3C, DW, k);
    wait_done();

    // Out-of-range accesses: write dropped, read returns zero, alias untouched.
    do_write(12'h100, 8'h5A, -1, 0, -1, 0);
    do_write(12'h900, 8'hFF, -1, 0, -1, 0);
    do_read(12'h900, 8'h00, DW, k);
    wait_done();
    do_read(12'h100, 8'h5A, DW, k);
    wait_done();

    // Reset during RDATA bit 3 aborts the burst after four bits.
    do_read(12'h123, 8'hA5, 4, k);
    r = rise_of(k);
    for (int i = 0; i < 100 && cyc < r + 3; i++) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    chk("rvalid_after_reset", int'(bus.rvalid), 0);
    chk("ready_after_reset", int'(bus.ready), 1);
    wait_done();
    do_read(12'h123, 8'hA5, DW, k);
    wait_done();

    // wvalid pulses during RLAT/RDATA are ignored.
    do_read(12'h7FF, 8'h3C, DW, k);
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      bus.wvalid = (i == 2 || i == 5 || i == 7 || i == 9);
      bus.wdata  = 1'b1;
      bus.mode   = 1'b1;
    end
    @(negedge clk);
    bus.wvalid = 1'b0;
    bus.mode   = 1'b0;
    bus.wdata  = 1'b0;
    wait_done();
    do_read(12'h7FF, 8'h3C, DW, k);
    wait_done();
    do_read(12'h123, 8'hA5, DW, k);
    wait_done();
    do_read(12'h100, 8'h5A, DW, k);
    wait_done();

`ifdef SLAVE_SPLIT_EN
    chk("short_latency_never_splits", split2_seen, 0);
`endif
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
